// File: rtl/hood_mode_scheduler_pkg.sv
// Shared types and constants for the range-hood mode sequencer.
// Also imported by the display path and onOffControl for the default timings.
package hood_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MENU  = 3'd1,
    ST_RUN1  = 3'd2,
    ST_RUN2  = 3'd3,
    ST_RUN3  = 3'd4,
    ST_RET3  = 3'd5,
    ST_CLEAN = 3'd6
  } state_t;

  localparam logic [2:0] MODE_STANDBY = 3'b000;
  localparam logic [2:0] MODE_L1      = 3'b001;
  localparam logic [2:0] MODE_L2      = 3'b010;
  localparam logic [2:0] MODE_L3      = 3'b011;
  localparam logic [2:0] MODE_CLEAN   = 3'b100;

  localparam int unsigned DEF_MODE3_SEC  = 60;
  localparam int unsigned DEF_RETURN_SEC = 60;
  localparam int unsigned DEF_CLEAN_SEC  = 180;
  localparam int unsigned DEF_REMIND_SEC = 36000;

  localparam int CNT_W = 8;
  localparam int CUM_W = 16;

  typedef enum logic [2:0] {
    P_NONE  = 3'd0,
    P_MENU  = 3'd1,
    P_MODE3 = 3'd2,
    P_MODE2 = 3'd3,
    P_MODE1 = 3'd4,
    P_CLEAN = 3'd5
  } pulse_t;

  // Only the highest-priority pulse of a cycle is ever acted on.
  function automatic pulse_t pick_pulse(input logic menu, input logic m3,
                                        input logic m2, input logic m1,
                                        input logic cl);
    pulse_t p;
    if (menu)    p = P_MENU;
    else if (m3) p = P_MODE3;
    else if (m2) p = P_MODE2;
    else if (m1) p = P_MODE1;
    else if (cl) p = P_CLEAN;
    else         p = P_NONE;
    return p;
  endfunction

  function automatic logic [2:0] mode_of(input state_t s);
    logic [2:0] m;
    case (s)
      ST_RUN1:          m = MODE_L1;
      ST_RUN2:          m = MODE_L2;
      ST_RUN3, ST_RET3: m = MODE_L3;
      ST_CLEAN:         m = MODE_CLEAN;
      default:          m = MODE_STANDBY;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/hood_mode_scheduler_countdown.sv
// Loadable down-counter used for the timed phases (level 3, return delay, clean).
// The caller is responsible for not enabling it at zero.
module hood_countdown
  import hood_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk_1hz,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         is_zero,
  output logic         is_one
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en) begin
      r_count <= r_count - W'(1);
    end
  end

  assign count   = r_count;
  assign is_zero = (r_count == '0);
  assign is_one  = (r_count == W'(1));

endmodule

// File: rtl/hood_mode_scheduler.sv
// Range-hood mode sequencer: menu/level/clean FSM, timed-phase countdown,
// accumulated run time and cleaning reminder. All outputs are registered.
module hood_mode_scheduler
  import hood_pkg::*;
#(
  parameter int unsigned MODE3_SEC  = DEF_MODE3_SEC,
  parameter int unsigned RETURN_SEC = DEF_RETURN_SEC,
  parameter int unsigned CLEAN_SEC  = DEF_CLEAN_SEC,
  parameter int unsigned REMIND_SEC = DEF_REMIND_SEC
) (
  input  logic             clk_1hz,
  input  logic             rst,
  input  logic             power_on,
  input  logic             menu_pulse,
  input  logic             mode1_pulse,
  input  logic             mode2_pulse,
  input  logic             mode3_pulse,
  input  logic             clean_pulse,
  output logic [2:0]       mode_state,
  output logic             menu_active,
  output logic [CNT_W-1:0] countdown,
  output logic [CUM_W-1:0] cumulative_time,
  output logic             clean_remind,
  output logic             mode3_used
);

  localparam logic [CNT_W-1:0] L_MODE3  = CNT_W'(MODE3_SEC);
  localparam logic [CNT_W-1:0] L_RETURN = CNT_W'(RETURN_SEC);
  localparam logic [CNT_W-1:0] L_CLEAN  = CNT_W'(CLEAN_SEC);

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_mode_state;
  logic             r_menu_active;
  logic [CUM_W-1:0] r_cum;
  logic [CUM_W-1:0] w_cum_next;
  logic             r_clean_remind;
  logic             r_mode3_used;

  pulse_t           w_pulse;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_tick;
  logic             w_cnt_en;
  logic             w_clean_done;
  logic             w_set_used;
  logic             w_running;
  logic [CNT_W-1:0] w_count;
  logic             w_cnt_zero;
  logic             w_cnt_one;

  assign w_pulse  = pick_pulse(menu_pulse, mode3_pulse, mode2_pulse,
                               mode1_pulse, clean_pulse);
  assign w_cnt_en = w_tick && !w_cnt_zero;

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_tick       = 1'b0;
    w_clean_done = 1'b0;
    w_set_used   = 1'b0;
    if (!power_on) begin
      w_state_next = ST_IDLE;
      w_load       = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pulse == P_MENU) w_state_next = ST_MENU;
        end
        ST_MENU: begin
          case (w_pulse)
            P_MENU:  w_state_next = ST_IDLE;
            P_MODE3: begin
              if (!r_mode3_used) begin
                w_state_next = ST_RUN3;
                w_load       = 1'b1;
                w_load_val   = L_MODE3;
                w_set_used   = 1'b1;
              end
            end
            P_MODE2: w_state_next = ST_RUN2;
            P_MODE1: w_state_next = ST_RUN1;
            P_CLEAN: begin
              w_state_next = ST_CLEAN;
              w_load       = 1'b1;
              w_load_val   = L_CLEAN;
            end
            default: w_state_next = ST_MENU;
          endcase
        end
        ST_RUN1, ST_RUN2: begin
          case (w_pulse)
            P_MENU:  w_state_next = ST_IDLE;
            P_MODE2: w_state_next = ST_RUN2;
            P_MODE1: w_state_next = ST_RUN1;
            default: w_state_next = r_state;
          endcase
        end
        ST_RUN3: begin
          if (w_pulse == P_MENU) begin
            w_state_next = ST_RET3;
            w_load       = 1'b1;
            w_load_val   = L_RETURN;
          end else begin
            w_tick = 1'b1;
            if (w_cnt_one) w_state_next = ST_RUN2;
          end
        end
        ST_RET3: begin
          w_tick = 1'b1;
          if (w_cnt_one) w_state_next = ST_IDLE;
        end
        ST_CLEAN: begin
          w_tick = 1'b1;
          if (w_cnt_one) begin
            w_state_next = ST_IDLE;
            w_clean_done = 1'b1;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Run time counts the state being left, so the cycle that powers off still counts.
  assign w_running = (r_state == ST_RUN1) || (r_state == ST_RUN2) ||
                     (r_state == ST_RUN3) || (r_state == ST_RET3);

  always_comb begin
    w_cum_next = r_cum;
    if (w_clean_done) begin
      w_cum_next = '0;
    end else if (w_running && (r_cum != {CUM_W{1'b1}})) begin
      w_cum_next = r_cum + CUM_W'(1);
    end
  end

  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_mode_state   <= MODE_STANDBY;
      r_menu_active  <= 1'b0;
      r_cum          <= '0;
      r_clean_remind <= 1'b0;
      r_mode3_used   <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_mode_state   <= mode_of(w_state_next);
      r_menu_active  <= (w_state_next == ST_MENU);
      r_cum          <= w_cum_next;
      r_clean_remind <= (32'(w_cum_next) >= REMIND_SEC);
      if (!power_on)       r_mode3_used <= 1'b0;
      else if (w_set_used) r_mode3_used <= 1'b1;
    end
  end

  hood_countdown #(
    .W (CNT_W)
  ) u_countdown (
    .clk_1hz  (clk_1hz),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .en       (w_cnt_en),
    .count    (w_count),
    .is_zero  (w_cnt_zero),
    .is_one   (w_cnt_one)
  );

  assign mode_state      = r_mode_state;
  assign menu_active     = r_menu_active;
  assign countdown       = w_count;
  assign cumulative_time = r_cum;
  assign clean_remind    = r_clean_remind;
  assign mode3_used      = r_mode3_used;

endmodule
